// File: rtl/nand_phy_pkg.sv
// rtl/nand_phy_pkg.sv - shared op codes, FSM encodings and helpers for the async NAND sequencer
package nand_phy_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] OP_CMD  = 2'b00;
    localparam logic [1:0] OP_ADDR = 2'b01;
    localparam logic [1:0] OP_DIN  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_WE_LOW  = 3'd2;
    localparam logic [2:0] ST_WE_HIGH = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    // Active-low chip enable vector selecting one die
    function automatic logic [7:0] ce_mask(input logic [2:0] sel);
        ce_mask = ~(8'd1 << sel);
    endfunction

endpackage

// File: rtl/nand_phase_timer.sv
// rtl/nand_phase_timer.sv - loadable 4-bit phase downcounter with done pulse
module nand_phase_timer
    import nand_phy_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = running && (cnt == '0);

endmodule

// File: rtl/nand_async_cmd_seq.sv
// rtl/nand_async_cmd_seq.sv - async-mode CMD/ADDR/DIN byte sequencer driving nand_phy control pins
module nand_async_cmd_seq
    import nand_phy_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_WP    = 3,
    parameter int T_WH    = 2,
    parameter int T_HOLD  = 4
) (
    input  logic       v_clk0,
    input  logic       v_rstn0,
    input  logic       v_op_valid,
    output logic       v_op_ready,
    input  logic [1:0] v_op_type,
    input  logic [7:0] v_op_data,
    input  logic       v_op_last,
    input  logic [2:0] v_op_ce_sel,
    input  logic       v_wp_n,
    output logic       v_op_err,
    output logic       v_busy,
    output logic       v_ctrl_cle,
    output logic       v_ctrl_ale,
    output logic       v_ctrl_wrn,
    output logic       v_ctrl_wpn,
    output logic [7:0] v_ctrl_cen,
    output logic       v_ctrl_wen,
    output logic       v_ctrl_wen_sel,
    output logic       v_dq_oe_n,
    output logic       v_dqs_oe_n,
    output logic [7:0] v_wr_data_rise,
    output logic [7:0] v_wr_data_fall
);

    logic [2:0]       st, st_n;
    logic             burst_open, burst_n;
    logic             last_q;
    logic             accept, is_rsvd;
    logic             tmr_start, tmr_done;
    logic [CNT_W-1:0] tmr_load;

    assign accept  = v_op_valid && v_op_ready;
    assign is_rsvd = (v_op_type == OP_RSVD);

    nand_phase_timer u_timer (
        .clk      (v_clk0),
        .resetn   (v_rstn0),
        .start    (tmr_start),
        .load_val (tmr_load),
        .done     (tmr_done)
    );

    always_comb begin
        st_n      = st;
        tmr_start = 1'b0;
        tmr_load  = '0;
        burst_n   = burst_open;
        case (st)
            ST_IDLE: begin
                if (accept) begin
                    if (is_rsvd) begin
                        st_n = ST_ERR;
                    end else begin
                        st_n      = ST_SETUP;
                        tmr_start = 1'b1;
                        tmr_load  = CNT_W'(T_SETUP - 1);
                        burst_n   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    st_n      = ST_WE_LOW;
                    tmr_start = 1'b1;
                    tmr_load  = CNT_W'(T_WP - 1);
                end
            end
            ST_WE_LOW: begin
                if (tmr_done) begin
                    st_n      = ST_WE_HIGH;
                    tmr_start = 1'b1;
                    tmr_load  = CNT_W'(T_WH - 1);
                end
            end
            ST_WE_HIGH: begin
                if (tmr_done) begin
                    if (last_q) begin
                        st_n      = ST_HOLD;
                        tmr_start = 1'b1;
                        tmr_load  = CNT_W'(T_HOLD - 1);
                    end else begin
                        st_n = ST_IDLE;
                    end
                end
            end
            // A reserved op never opens a burst, but may close one that is already open
            ST_ERR: begin
                if (last_q && burst_open) begin
                    st_n      = ST_HOLD;
                    tmr_start = 1'b1;
                    tmr_load  = CNT_W'(T_HOLD - 1);
                end else begin
                    st_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    st_n    = ST_IDLE;
                    burst_n = 1'b0;
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge v_clk0) begin
        if (!v_rstn0) begin
            st             <= ST_IDLE;
            burst_open     <= 1'b0;
            last_q         <= 1'b0;
            v_op_ready     <= 1'b1;
            v_busy         <= 1'b0;
            v_op_err       <= 1'b0;
            v_ctrl_cle     <= 1'b0;
            v_ctrl_ale     <= 1'b0;
            v_ctrl_wen     <= 1'b1;
            v_ctrl_cen     <= 8'hFF;
            v_dq_oe_n      <= 1'b1;
            v_wr_data_rise <= 8'h00;
            v_ctrl_wpn     <= 1'b0;
        end else begin
            st         <= st_n;
            burst_open <= burst_n;
            v_op_ready <= (st_n == ST_IDLE);
            v_busy     <= (st_n != ST_IDLE) || burst_n;
            v_op_err   <= accept && is_rsvd;
            v_ctrl_wen <= (st_n != ST_WE_LOW);
            v_ctrl_wpn <= v_wp_n;
            if (accept) begin
                last_q <= v_op_last;
            end
            if (accept && !is_rsvd) begin
                v_ctrl_cle     <= (v_op_type == OP_CMD);
                v_ctrl_ale     <= (v_op_type == OP_ADDR);
                v_dq_oe_n      <= 1'b0;
                v_wr_data_rise <= v_op_data;
                if (!burst_open) begin
                    v_ctrl_cen <= ce_mask(v_op_ce_sel);
                end
            end
            if ((st_n == ST_HOLD) && (st != ST_HOLD)) begin
                v_ctrl_cle <= 1'b0;
                v_ctrl_ale <= 1'b0;
                v_dq_oe_n  <= 1'b1;
            end
            if ((st == ST_HOLD) && (st_n == ST_IDLE)) begin
                v_ctrl_cen <= 8'hFF;
            end
        end
    end

    assign v_ctrl_wrn     = 1'b1;
    assign v_ctrl_wen_sel = 1'b1;
    assign v_dqs_oe_n     = 1'b1;
    assign v_wr_data_fall = v_wr_data_rise;

endmodule

// File: tb/tb_nand_async_cmd_seq.sv
// tb/tb_nand_async_cmd_seq.sv - randomized self-checking bench for nand_async_cmd_seq
module tb_nand_async_cmd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       wp_n;
    logic       op_valid [2];
    logic [1:0] op_type  [2];
    logic [7:0] op_data  [2];
    logic       op_last  [2];
    logic [2:0] op_sel   [2];
    logic       rdy [2], err [2], bsy [2], cle [2], ale [2], wrn [2], wpn [2];
    logic       wen [2], wsel [2], oe [2], dqs [2];
    logic [7:0] cen [2], wdr [2], wdf [2];

    nand_async_cmd_seq #(.T_SETUP(2), .T_WP(3), .T_WH(2), .T_HOLD(4)) u_dut0 (
        .v_clk0(clk), .v_rstn0(rstn), .v_op_valid(op_valid[0]), .v_op_ready(rdy[0]),
        .v_op_type(op_type[0]), .v_op_data(op_data[0]), .v_op_last(op_last[0]),
        .v_op_ce_sel(op_sel[0]), .v_wp_n(wp_n), .v_op_err(err[0]), .v_busy(bsy[0]),
        .v_ctrl_cle(cle[0]), .v_ctrl_ale(ale[0]), .v_ctrl_wrn(wrn[0]), .v_ctrl_wpn(wpn[0]),
        .v_ctrl_cen(cen[0]), .v_ctrl_wen(wen[0]), .v_ctrl_wen_sel(wsel[0]), .v_dq_oe_n(oe[0]),
        .v_dqs_oe_n(dqs[0]), .v_wr_data_rise(wdr[0]), .v_wr_data_fall(wdf[0])
    );

    nand_async_cmd_seq #(.T_SETUP(1), .T_WP(1), .T_WH(1), .T_HOLD(1)) u_dut1 (
        .v_clk0(clk), .v_rstn0(rstn), .v_op_valid(op_valid[1]), .v_op_ready(rdy[1]),
        .v_op_type(op_type[1]), .v_op_data(op_data[1]), .v_op_last(op_last[1]),
        .v_op_ce_sel(op_sel[1]), .v_wp_n(wp_n), .v_op_err(err[1]), .v_busy(bsy[1]),
        .v_ctrl_cle(cle[1]), .v_ctrl_ale(ale[1]), .v_ctrl_wrn(wrn[1]), .v_ctrl_wpn(wpn[1]),
        .v_ctrl_cen(cen[1]), .v_ctrl_wen(wen[1]), .v_ctrl_wen_sel(wsel[1]), .v_dq_oe_n(oe[1]),
        .v_dqs_oe_n(dqs[1]), .v_wr_data_rise(wdr[1]), .v_wr_data_fall(wdf[1])
    );

    int ts  [2] = '{2, 1};
    int twp [2] = '{3, 1};
    int twh [2] = '{2, 1};
    int th  [2] = '{4, 1};
    int checks = 0;
    int errors = 0;

    // Reference view of each sequencer's bus: burst state and the levels it should hold
    logic       m_open [2];
    logic [7:0] m_cen  [2];
    logic [7:0] m_wd   [2];
    logic       m_cle  [2], m_ale [2], m_oe [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] got_vec(input int d);
        return 64'({rdy[d], bsy[d], err[d], cle[d], ale[d], wen[d], oe[d],
                    wrn[d], wsel[d], dqs[d], cen[d], wdr[d], wdf[d]});
    endfunction

    function automatic logic [63:0] mk(input logic r, input logic b, input logic e,
                                       input logic c, input logic a, input logic w,
                                       input logic o, input logic [7:0] ce, input logic [7:0] wd);
        return 64'({r, b, e, c, a, w, o, 3'b111, ce, wd, wd});
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_open[d] = 1'b0; m_cen[d] = 8'hFF; m_wd[d] = 8'h00;
            m_cle[d] = 1'b0; m_ale[d] = 1'b0; m_oe[d] = 1'b1;
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        check_eq("idle", got_vec(d), mk(1'b1, m_open[d], 1'b0, m_cle[d], m_ale[d], 1'b1,
                                         m_oe[d], m_cen[d], m_wd[d]));
    endtask

    // Called at a negedge; drives one op and checks every cycle up to and including re-ready
    task automatic do_op(input int d, input logic [1:0] typ, input logic [7:0] data,
                         input logic last, input logic [2:0] sel);
        int act;
        int n;
        logic hold_run;
        logic we_low;
        logic [63:0] e;
        string tag;
        op_valid[d] = 1'b1; op_type[d] = typ; op_data[d] = data;
        op_last[d] = last; op_sel[d] = sel;
        check_eq("ready", 64'(rdy[d]), 64'd1);
        if (typ != 2'b11) begin
            if (!m_open[d]) begin
                m_open[d] = 1'b1;
                m_cen[d]  = ~(8'd1 << sel);
            end
            m_cle[d] = (typ == 2'b00); m_ale[d] = (typ == 2'b01);
            m_oe[d] = 1'b0; m_wd[d] = data;
            act = ts[d] + twp[d] + twh[d];
            hold_run = last;
            tag = "op";
        end else begin
            act = 1;
            hold_run = last && m_open[d];
            tag = "rsvd";
        end
        n = act + (hold_run ? th[d] : 0);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                op_valid[d] = 1'b0;
                op_data[d]  = 8'($urandom);
                op_sel[d]   = 3'($urandom);
            end
            if (hold_run && k == act + 1) begin
                m_cle[d] = 1'b0; m_ale[d] = 1'b0; m_oe[d] = 1'b1;
            end
            if (hold_run && k == n + 1) begin
                m_open[d] = 1'b0; m_cen[d] = 8'hFF;
            end
            we_low = (typ != 2'b11) && (k > ts[d]) && (k <= ts[d] + twp[d]);
            if (k <= n)
                e = mk(1'b0, 1'b1, (typ == 2'b11) && (k == 1), m_cle[d], m_ale[d], !we_low,
                       m_oe[d], m_cen[d], m_wd[d]);
            else
                e = mk(1'b1, m_open[d], 1'b0, m_cle[d], m_ale[d], 1'b1,
                       m_oe[d], m_cen[d], m_wd[d]);
            check_eq(tag, got_vec(d), e);
        end
    endtask

    task automatic burst(input int d, input int nops);
        logic [1:0] typ;
        for (int i = 0; i < nops; i++) begin
            typ = (i == 0) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            do_op(d, typ, 8'($urandom), (i == nops - 1), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) idle(d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; wp_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            op_valid[d] = 1'b0; op_type[d] = 2'b00; op_data[d] = 8'h00;
            op_last[d] = 1'b0; op_sel[d] = 3'd0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset", got_vec(d), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00));
            check_eq("reset_wpn", 64'(wpn[d]), 64'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        wp_n = 1'b1;
        @(negedge clk);
        check_eq("wpn_hi", 64'({wpn[1], wpn[0]}), 64'd3);
        wp_n = 1'b0;
        @(negedge clk);
        check_eq("wpn_lo", 64'({wpn[1], wpn[0]}), 64'd0);

        // Reset in the middle of the WE# low phase
        op_valid[0] = 1'b1; op_type[0] = 2'b00; op_data[0] = 8'h70;
        op_last[0] = 1'b1; op_sel[0] = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) op_valid[0] = 1'b0;
        end
        check_eq("rst_pre_wen", 64'({wen[0], cen[0]}), 64'({1'b0, 8'hFE}));
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check_eq("rst_hold", got_vec(0), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00));
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_after", got_vec(0), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00));

        do_op(0, 2'b00, 8'hFF, 1'b1, 3'd2);
        do_op(0, 2'b00, 8'h90, 1'b0, 3'd5);
        do_op(0, 2'b01, 8'h00, 1'b1, 3'd1);
        idle(0);
        do_op(0, 2'b01, 8'h11, 1'b0, 3'd3);
        do_op(0, 2'b01, 8'h22, 1'b0, 3'd3);
        do_op(0, 2'b01, 8'h33, 1'b0, 3'd6);
        do_op(0, 2'b01, 8'h44, 1'b0, 3'd3);
        do_op(0, 2'b01, 8'h55, 1'b1, 3'd3);
        do_op(0, 2'b00, 8'h00, 1'b0, 3'd1);
        do_op(0, 2'b11, 8'hA5, 1'b0, 3'd4);
        do_op(0, 2'b00, 8'h30, 1'b1, 3'd4);
        do_op(0, 2'b10, 8'h5A, 1'b0, 3'd7);
        do_op(0, 2'b11, 8'h00, 1'b1, 3'd0);

        for (int b = 0; b < 15; b++) burst(0, $urandom_range(1, 5));
        do_op(1, 2'b00, 8'hEF, 1'b0, 3'd6);
        do_op(1, 2'b10, 8'h3C, 1'b1, 3'd1);
        for (int b = 0; b < 10; b++) burst(1, $urandom_range(1, 5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
